// File: rtl/pwm_pkg.sv
// Shared PWM definitions: dead-time FSM state encoding and counter mode constants.
package pwm_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_L_ON  = 3'd1,
    ST_DT_LH = 3'd2,
    ST_H_ON  = 3'd3,
    ST_DT_HL = 3'd4
  } pwm_dt_state_t;

  localparam logic MODE_UP     = 1'b0;
  localparam logic MODE_UPDOWN = 1'b1;

endpackage

// File: rtl/pwm_compare_dt_if.sv
// Signal bundle between the PWM counter/config side and the compare + dead-time stage.
interface pwm_compare_dt_if #(
  parameter int WIDTH    = 8,
  parameter int DT_WIDTH = 4
);
  logic                PWM_EN;
  logic                mode;
  logic [WIDTH-1:0]    period;
  logic [WIDTH-1:0]    cnt_val;
  logic [WIDTH-1:0]    duty;
  logic                duty_wr;
  logic [DT_WIDTH-1:0] deadtime;
  logic                pwm_h;
  logic                pwm_l;
  logic [WIDTH-1:0]    duty_active;
  logic                period_evt;

  modport master (
    output PWM_EN, mode, period, cnt_val, duty, duty_wr, deadtime,
    input  pwm_h, pwm_l, duty_active, period_evt
  );

  modport slave (
    input  PWM_EN, mode, period, cnt_val, duty, duty_wr, deadtime,
    output pwm_h, pwm_l, duty_active, period_evt
  );
endinterface

// File: rtl/pwm_compare_dt_deadtime.sv
// Complementary gate driver. With PWM_DEADTIME_EN defined a dead-time FSM inserts both-low
// gaps on every side change; otherwise the gates simply follow raw_q.
module pwm_deadtime #(
  parameter int DT_WIDTH = 4
) (
  input  logic                clk,
  input  logic                cmp_rst_n,
  input  logic                raw_q,
  input  logic                PWM_EN,
  input  logic [DT_WIDTH-1:0] deadtime,
  output logic                pwm_h,
  output logic                pwm_l
);

  logic r_pwm_h;
  logic r_pwm_l;

`ifdef PWM_DEADTIME_EN
  import pwm_pkg::*;

  // state    | meaning
  // OFF      | disabled or reset, both gates low
  // L_ON     | low side driven
  // DT_LH    | both low, counting down before high side turns on
  // H_ON     | high side driven
  // DT_HL    | both low, counting down before low side turns on

  localparam logic [DT_WIDTH-1:0] DT_ONE = DT_WIDTH'(1);

  pwm_dt_state_t       r_state;
  pwm_dt_state_t       w_state_nxt;
  logic [DT_WIDTH-1:0] r_dt_cnt;
  logic [DT_WIDTH-1:0] w_dt_cnt_nxt;

  always_ff @(posedge clk) begin
    if (!cmp_rst_n) begin
      r_state  <= ST_OFF;
      r_dt_cnt <= '0;
      r_pwm_h  <= 1'b0;
      r_pwm_l  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_dt_cnt <= w_dt_cnt_nxt;
      r_pwm_h  <= (w_state_nxt == ST_H_ON);
      r_pwm_l  <= (w_state_nxt == ST_L_ON);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_dt_cnt_nxt = r_dt_cnt;
    case (r_state)
      ST_OFF:   w_state_nxt = raw_q ? ST_H_ON : ST_L_ON;
      ST_L_ON: begin
        if (raw_q) begin
          if (deadtime == '0) begin
            w_state_nxt = ST_H_ON;
          end else begin
            w_state_nxt  = ST_DT_LH;
            w_dt_cnt_nxt = deadtime;
          end
        end
      end
      ST_DT_LH: begin
        w_dt_cnt_nxt = r_dt_cnt - DT_ONE;
        if (!raw_q)                 w_state_nxt = ST_L_ON;
        else if (r_dt_cnt <= DT_ONE) w_state_nxt = ST_H_ON;
      end
      ST_H_ON: begin
        if (!raw_q) begin
          if (deadtime == '0) begin
            w_state_nxt = ST_L_ON;
          end else begin
            w_state_nxt  = ST_DT_HL;
            w_dt_cnt_nxt = deadtime;
          end
        end
      end
      ST_DT_HL: begin
        w_dt_cnt_nxt = r_dt_cnt - DT_ONE;
        if (raw_q)                  w_state_nxt = ST_H_ON;
        else if (r_dt_cnt <= DT_ONE) w_state_nxt = ST_L_ON;
      end
      default:  w_state_nxt = ST_OFF;
    endcase
    // Disable wins over every transition and drops the count.
    if (!PWM_EN) begin
      w_state_nxt  = ST_OFF;
      w_dt_cnt_nxt = '0;
    end
  end
`else
  logic w_unused_dt;
  assign w_unused_dt = ^deadtime;

  always_ff @(posedge clk) begin
    if (!cmp_rst_n) begin
      r_pwm_h <= 1'b0;
      r_pwm_l <= 1'b0;
    end else begin
      r_pwm_h <= PWM_EN & raw_q;
      r_pwm_l <= PWM_EN & ~raw_q;
    end
  end
`endif

  assign pwm_h = r_pwm_h;
  assign pwm_l = r_pwm_l;

endmodule

// File: rtl/pwm_compare_dt.sv
// PWM compare stage: double-buffered duty, period boundary strobe, raw compare, gate pair.
// Dead-time insertion is built only when PWM_DEADTIME_EN is defined.
module pwm_compare_dt
  import pwm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DT_WIDTH = 4
) (
  input  logic             clk,
  input  logic             cmp_rst_n,
  pwm_compare_dt_if.slave  bus
);

  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_active;
  logic             r_raw_q;
  logic             r_evt;
  logic             w_boundary;
  logic [WIDTH-1:0] w_shadow_nxt;
  logic             w_pwm_h;
  logic             w_pwm_l;

  assign w_boundary   = (bus.mode == MODE_UP) ? (bus.cnt_val == bus.period)
                                              : (bus.cnt_val == '0);
  // A write landing on the boundary cycle bypasses straight into the active register.
  assign w_shadow_nxt = bus.duty_wr ? bus.duty : r_shadow;

  always_ff @(posedge clk) begin
    if (!cmp_rst_n) begin
      r_shadow <= '0;
      r_active <= '0;
      r_raw_q  <= 1'b0;
      r_evt    <= 1'b0;
    end else begin
      r_shadow <= w_shadow_nxt;
      if (!bus.PWM_EN)     r_active <= r_shadow;
      else if (w_boundary) r_active <= w_shadow_nxt;
      r_evt   <= bus.PWM_EN & w_boundary;
      r_raw_q <= (bus.cnt_val < r_active);
    end
  end

  pwm_deadtime #(
    .DT_WIDTH (DT_WIDTH)
  ) u_deadtime (
    .clk       (clk),
    .cmp_rst_n (cmp_rst_n),
    .raw_q     (r_raw_q),
    .PWM_EN    (bus.PWM_EN),
    .deadtime  (bus.deadtime),
    .pwm_h     (w_pwm_h),
    .pwm_l     (w_pwm_l)
  );

  assign bus.pwm_h       = w_pwm_h;
  assign bus.pwm_l       = w_pwm_l;
  assign bus.duty_active = r_active;
  assign bus.period_evt  = r_evt;

endmodule

// File: doc/pwm_compare_dt.md
# pwm_compare_dt

Complementary PWM output stage that sits directly downstream of the PWM `counter`. It compares the counter's `cnt_val` against a double-buffered duty value and produces a high-side/low-side gate pair with programmable dead-time. It also emits a period-boundary strobe. Duty updates take effect only at period boundaries, so a write cannot produce a glitch.

## Interface
- `WIDTH`, 8: width of `cnt_val`, `period`, `duty`; must match the counter.
- `DT_WIDTH`, 4: width of the dead-time count.
- `clk`  in  1: single clock, rising edge.
- `cmp_rst_n`  in  1: reset, synchronous, active-low.
- `PWM_EN`  in  1: enable, same signal that drives the counter.
- `mode`  in  1: 0 = up (edge-aligned), 1 = up-down (center-aligned).
- `period`  in  WIDTH: counter terminal value.
- `cnt_val`  in  WIDTH: counter output.
- `duty`  in  WIDTH: new compare value.
- `duty_wr`  in  1: one-cycle strobe that writes `duty` into the shadow register.
- `deadtime`  in  DT_WIDTH: dead-time in clk cycles; 0 means none.
- `pwm_h`  out  1: high-side gate, registered.
- `pwm_l`  out  1: low-side gate, registered.
- `duty_active`  out  WIDTH: compare value currently in use.
- `period_evt`  out  1: one-cycle pulse at each period boundary.

## Operation
- **Counter convention:**
  - Up mode: 0..`period`, then wraps to 0.
  - Up-down mode: 0..`period`..1, then 0.
- **Shadow register:**
  - `duty_wr` loads `shadow`.
  - `duty_active` loads `shadow` at the boundary.
  - Up mode boundary: `cnt_val == period`.
  - Up-down mode boundary: `cnt_val == 0`.
  - While `PWM_EN = 0`, `duty_active` follows `shadow` every cycle.
  - If `duty_wr` and the boundary occur in the same cycle, the written value goes straight to `duty_active` (bypass).
- **`period_evt`:** registered pulse on the boundary cycle; only while `PWM_EN = 1`.
- **Raw compare:** `raw = (cnt_val < duty_active)`, unsigned, registered into `raw_q`.
  - `duty_active = 0` gives 0 %.
  - `duty_active > period` gives 100 %.
- **Dead-time FSM states:** OFF, L_ON, DT_LH, H_ON, DT_HL.
  - OFF: both outputs low. Entered on reset or when `PWM_EN = 0`, from any state, on the next edge. The dead-time counter is cleared.
  - OFF with `PWM_EN = 1`: go to H_ON if `raw_q`, else L_ON. No dead-time is applied, since both sides are already off.
  - L_ON with `raw_q = 1`: go to DT_LH (both low) and load the counter with `deadtime`. If `deadtime = 0`, go directly to H_ON.
  - DT_LH: decrement the counter each cycle; go to H_ON after `deadtime` cycles. If `raw_q` falls back to 0 during DT_LH, return to L_ON on the next edge.
  - H_ON, DT_HL: symmetric to L_ON, DT_LH.
- **Invariant:** `pwm_h & pwm_l` is never 1.
- **Run-time changes:** `deadtime` is sampled only on DT entry. `mode` and `period` changes take effect immediately.

## Timing
- **Reset values:** `pwm_h = 0`, `pwm_l = 0`, `period_evt = 0`, `duty_active = 0`, shadow 0, state OFF, dead-time counter 0.
- **Turn-off edge:** 2 cycles after the `cnt_val` sample that changes `raw` (1 cycle to `raw_q`, 1 cycle to the output register).
- **Turn-on edge:** 2 + `deadtime` cycles.
- **`period_evt`:** asserted 1 cycle after the boundary `cnt_val` is presented.
- **Boundary load:** `duty_active` is updated on the boundary edge. The new value first affects the compare of the next `cnt_val`.
- **Disable:** `PWM_EN` falling forces both outputs low 1 cycle later.

## Configuration
- **`PWM_DEADTIME_EN` defined:** full FSM as above.
- **`PWM_DEADTIME_EN` undefined:**
  - No DT states and no counter; `deadtime` is ignored.
  - When enabled: `pwm_h = raw_q`, `pwm_l = ~raw_q`, registered.
  - When disabled: both outputs 0.

## Structure
- **Shared package `pwm_pkg`:**
  - FSM state enum `pwm_dt_state_t`.
  - Constants `MODE_UP = 1'b0`, `MODE_UPDOWN = 1'b1`.
  - Shared with `counter`.
- **Sub-module `pwm_deadtime`:** FSM plus dead-time counter.
  - Inputs: `raw_q`, `PWM_EN`, `deadtime`.
  - Outputs: `pwm_h`, `pwm_l`.
  - The top level holds the shadow/active registers, the compare and the boundary detection.

## Test plan
1. **Reset:** hold `cmp_rst_n = 0` for 2 cycles with `PWM_EN = 1` → `pwm_h = pwm_l = 0`, `duty_active = 0`, `period_evt = 0` throughout.
2. **Up mode, dead-time 2:** `period = 10`, `duty` written to 4, `deadtime = 2` → after the first boundary, each 11-cycle period has `pwm_h` high 2 cycles, `pwm_l` high 5 cycles, and two 2-cycle both-low gaps. `period_evt` pulses once per 11 cycles.
3. **Up-down mode:** `mode = 1`, `period = 10`, `duty = 4`, `deadtime = 0` → 20-cycle period, `pwm_h` high 7 consecutive cycles centered on `cnt_val = 0`, `pwm_l = ~pwm_h`.
4. **Shadow update:** `duty_wr` with `duty = 8` at `cnt_val = 5` (up mode) → `duty_active` stays 4 until the `cnt_val = 10` edge, then becomes 8. Repeat with `duty_wr` exactly at `cnt_val = 10` → bypass, `duty_active = 8` on that edge.
5. **Boundary duties:** `duty = 0` → `pwm_h` never high. `duty = 11` → `pwm_l` never high after entry.
6. **Mid-run disable:** `PWM_EN` 1→0 during DT_LH → both outputs low next cycle. Re-enable with `raw_q = 1` → `pwm_h` high with no dead-time; overlap check holds every cycle.
